// File: rtl/mux8_sel_sequencer.sv
// Byte serializer driving an 8:1 mux: holds a byte on mux_data, steps mux_sel,
// registers mux_out into a framed serial stream with optional even parity.
// Ports: clk, rst (sync, active-high); in_data/in_valid/in_ready byte input;
// mux_data/mux_sel to the mux, mux_out back from it;
// ser_out/ser_valid/ser_last serial stream; busy while a frame is in flight.
module mux8_sel_sequencer #(
  parameter bit MSB_FIRST = 1'b0,
  parameter bit PARITY_EN = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] in_data,
  input  logic       in_valid,
  output logic       in_ready,
  output logic [7:0] mux_data,
  output logic [2:0] mux_sel,
  input  logic       mux_out,
  output logic       ser_out,
  output logic       ser_valid,
  output logic       ser_last,
  output logic       busy
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHIFT  = 2'd1,
    PARITY = 2'd2
  } state_t;

  state_t     state;
  logic [2:0] cnt;
  logic       par;

  assign in_ready = (state == IDLE);
  assign busy     = ~in_ready;

  // cnt rests at 0 outside SHIFT, so sel idles at 0 (LSB) or 7 (MSB)
  assign mux_sel = MSB_FIRST ? (3'd7 - cnt) : cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= 3'd0;
      par       <= 1'b0;
      mux_data  <= 8'd0;
      ser_out   <= 1'b0;
      ser_valid <= 1'b0;
      ser_last  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          ser_valid <= 1'b0;
          ser_last  <= 1'b0;
          if (in_valid) begin
            mux_data <= in_data;
            cnt      <= 3'd0;
            par      <= 1'b0;
            state    <= SHIFT;
          end
        end
        SHIFT: begin
          ser_out   <= mux_out;
          ser_valid <= 1'b1;
          par       <= par ^ mux_out;
          cnt       <= cnt + 3'd1;
          ser_last  <= 1'b0;
          if (cnt == 3'd7) begin
            if (PARITY_EN) begin
              state <= PARITY;
            end else begin
              state    <= IDLE;
              ser_last <= 1'b1;
            end
          end
        end
        PARITY: begin
          ser_out   <= par;
          ser_valid <= 1'b1;
          ser_last  <= 1'b1;
          state     <= IDLE;
        end
        default: begin
          state     <= IDLE;
          ser_valid <= 1'b0;
          ser_last  <= 1'b0;
        end
      endcase
    end
  end

endmodule
